// File: rtl/sap_pkg.sv
// sap_pkg: shared definitions for the SAP control sequencer.
//   - opcode values OP_HLT..OP_JZ (low four opcode bits)
//   - bit positions SIG_* of each signal in the 15-bit control word
//     (a trailing _N marks an active-low signal)
//   - CTRL_IDLE, the word with every signal deasserted
//   - stage encodings ST_T0..ST_T5, ST_RESET, ST_HALT
//   - sig_on(): asserts one signal in a control word, whatever its polarity
package sap_pkg;

  localparam logic [3:0] OP_HLT = 4'd0;
  localparam logic [3:0] OP_NOP = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_LDA = 4'd4;
  localparam logic [3:0] OP_OUT = 4'd5;
  localparam logic [3:0] OP_STA = 4'd6;
  localparam logic [3:0] OP_JMP = 4'd7;
  localparam logic [3:0] OP_JC  = 4'd8;
  localparam logic [3:0] OP_JZ  = 4'd9;

  localparam logic [3:0] SIG_C_P    = 4'd14;
  localparam logic [3:0] SIG_E_P    = 4'd13;
  localparam logic [3:0] SIG_L_P    = 4'd12;
  localparam logic [3:0] SIG_L_MA_N = 4'd11;
  localparam logic [3:0] SIG_L_MD_N = 4'd10;
  localparam logic [3:0] SIG_CE_N   = 4'd9;
  localparam logic [3:0] SIG_L_R_N  = 4'd8;
  localparam logic [3:0] SIG_L_I_N  = 4'd7;
  localparam logic [3:0] SIG_E_I_N  = 4'd6;
  localparam logic [3:0] SIG_L_A_N  = 4'd5;
  localparam logic [3:0] SIG_E_A    = 4'd4;
  localparam logic [3:0] SIG_S_U    = 4'd3;
  localparam logic [3:0] SIG_E_U    = 4'd2;
  localparam logic [3:0] SIG_L_B_N  = 4'd1;
  localparam logic [3:0] SIG_L_O_N  = 4'd0;

  // Active-low signals sit at 1, active-high signals at 0.
  localparam logic [14:0] CTRL_IDLE = 15'h0FE3;

  typedef enum logic [2:0] {
    ST_T0    = 3'd0,
    ST_T1    = 3'd1,
    ST_T2    = 3'd2,
    ST_T3    = 3'd3,
    ST_T4    = 3'd4,
    ST_T5    = 3'd5,
    ST_RESET = 3'd6,
    ST_HALT  = 3'd7
  } stage_t;

  // Asserting a signal means driving it to the opposite of its idle level.
  function automatic logic [14:0] sig_on(input logic [14:0] w, input logic [3:0] idx);
    logic [14:0] r;
    r      = w;
    r[idx] = ~CTRL_IDLE[idx];
    return r;
  endfunction

endpackage

// File: rtl/sap_microcode_rom.sv
// sap_microcode_rom: combinational microcode table.
// Ports:
//   stage      in   current micro-stage
//   opcode     in   IR opcode (OPCODE_W bits; any bit above [3:0] set = illegal)
//   flag_c     in   carry flag, selects the JC jump word in T3
//   flag_z     in   zero flag, selects the JZ jump word in T3
//   ctrl       out  control word for this stage (CTRL_IDLE outside T0-T5)
//   last_stage out  this stage completes the instruction
//   is_halt    out  T3 of HLT
//   is_illegal out  T3 of an illegal opcode
module sap_microcode_rom
  import sap_pkg::*;
#(
  parameter int OPCODE_W = 4
) (
  input  stage_t              stage,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                flag_c,
  input  logic                flag_z,
  output logic [14:0]         ctrl,
  output logic                last_stage,
  output logic                is_halt,
  output logic                is_illegal
);

  logic [OPCODE_W-1:0] op_hi;
  logic [3:0]          op_eff;
  logic [14:0]         jmp_word;
  logic [14:0]         mar_from_ir;

  // Illegal upper bits fold onto 4'hF, which falls into the illegal default.
  assign op_hi       = opcode >> 4;
  assign op_eff      = (|op_hi) ? 4'hF : opcode[3:0];
  assign jmp_word    = sig_on(sig_on(CTRL_IDLE, SIG_E_I_N), SIG_L_P);
  assign mar_from_ir = sig_on(sig_on(CTRL_IDLE, SIG_E_I_N), SIG_L_MA_N);

  always_comb begin
    ctrl       = CTRL_IDLE;
    last_stage = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    case (stage)
      ST_T0: ctrl = sig_on(sig_on(CTRL_IDLE, SIG_E_P), SIG_L_MA_N);
      ST_T1: ctrl = sig_on(CTRL_IDLE, SIG_C_P);
      ST_T2: ctrl = sig_on(sig_on(CTRL_IDLE, SIG_CE_N), SIG_L_I_N);
      ST_T3: begin
        last_stage = 1'b1;
        case (op_eff)
          OP_HLT: is_halt = 1'b1;
          OP_NOP: ctrl = CTRL_IDLE;
          OP_ADD, OP_SUB, OP_LDA, OP_STA: begin
            ctrl       = mar_from_ir;
            last_stage = 1'b0;
          end
          OP_OUT: ctrl = sig_on(sig_on(CTRL_IDLE, SIG_E_A), SIG_L_O_N);
          OP_JMP: ctrl = jmp_word;
          OP_JC:  ctrl = flag_c ? jmp_word : CTRL_IDLE;
          OP_JZ:  ctrl = flag_z ? jmp_word : CTRL_IDLE;
          default: is_illegal = 1'b1;
        endcase
      end
      ST_T4: begin
        // Opcodes that never reach T4 end the instruction here if the
        // opcode changes mid-flight, so the sequencer cannot get stuck.
        last_stage = 1'b1;
        case (op_eff)
          OP_ADD, OP_SUB: begin
            ctrl       = sig_on(sig_on(CTRL_IDLE, SIG_CE_N), SIG_L_B_N);
            last_stage = 1'b0;
          end
          OP_LDA: ctrl = sig_on(sig_on(CTRL_IDLE, SIG_CE_N), SIG_L_A_N);
          OP_STA: begin
            ctrl       = sig_on(sig_on(CTRL_IDLE, SIG_E_A), SIG_L_MD_N);
            last_stage = 1'b0;
          end
          default: ctrl = CTRL_IDLE;
        endcase
      end
      ST_T5: begin
        last_stage = 1'b1;
        case (op_eff)
          OP_ADD: ctrl = sig_on(sig_on(CTRL_IDLE, SIG_E_U), SIG_L_A_N);
          OP_SUB: ctrl = sig_on(sig_on(sig_on(CTRL_IDLE, SIG_E_U), SIG_L_A_N), SIG_S_U);
          OP_STA: ctrl = sig_on(CTRL_IDLE, SIG_L_R_N);
          default: ctrl = CTRL_IDLE;
        endcase
      end
      default: ctrl = CTRL_IDLE;
    endcase
  end

endmodule

// File: rtl/sap_control_sequencer.sv
// sap_control_sequencer: SAP fetch/execute stage sequencer.
// Ports:
//   clk, rst_n   clock (rising edge) and synchronous active-low reset
//   opcode       IR opcode, valid from T3 onward
//   flag_c/z     adder flags for JC/JZ
//   step_mode    1 = advance only on a step strobe
//   step         one-cycle advance strobe
//   resume       leave HALT (not subject to step gating)
//   ctrl         15-bit bus control word, idle whenever the stage does not advance
//   stage        0-5 = T0-T5, 6 = RESET, 7 = HALT (FSM state, exposed for debug)
//   halted       1 in HALT
//   illegal      1 during T3 of an illegal opcode
//   instr_count  retired instructions, wraps silently
// Handshake: ctrl is meaningful only in a cycle where advance is high; the
// stage register moves on the same rising edge that consumes that word.
module sap_control_sequencer
  import sap_pkg::*;
#(
  parameter int OPCODE_W     = 4,
  parameter int COUNT_W      = 16,
  parameter int STEP_EN      = 1,
  parameter int ILLEGAL_HALT = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                flag_c,
  input  logic                flag_z,
  input  logic                step_mode,
  input  logic                step,
  input  logic                resume,
  output logic [14:0]         ctrl,
  output logic [2:0]          stage,
  output logic                halted,
  output logic                illegal,
  output logic [COUNT_W-1:0]  instr_count
);

  stage_t             stage_q;
  stage_t             stage_d;
  logic [COUNT_W-1:0] count_q;
  logic               retire;
  logic               advance;
  logic [14:0]        rom_ctrl;
  logic               rom_last;
  logic               rom_halt;
  logic               rom_illegal;

  assign advance = !((STEP_EN != 0) && step_mode) || step;

  sap_microcode_rom #(
    .OPCODE_W (OPCODE_W)
  ) u_rom (
    .stage      (stage_q),
    .opcode     (opcode),
    .flag_c     (flag_c),
    .flag_z     (flag_z),
    .ctrl       (rom_ctrl),
    .last_stage (rom_last),
    .is_halt    (rom_halt),
    .is_illegal (rom_illegal)
  );

  // An instruction retires on the edge that leaves its last stage, including
  // HLT and an illegal opcode that halts.
  always_comb begin
    stage_d = stage_q;
    retire  = 1'b0;
    case (stage_q)
      ST_RESET: if (advance) stage_d = ST_T0;
      ST_HALT:  if (resume) stage_d = ST_T0;
      default: begin
        if (advance) begin
          if (rom_last) begin
            retire  = 1'b1;
            stage_d = (rom_halt || ((ILLEGAL_HALT != 0) && rom_illegal)) ? ST_HALT : ST_T0;
          end else begin
            stage_d = stage_t'(stage_q + 3'd1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_q <= ST_RESET;
      count_q <= '0;
    end else begin
      stage_q <= stage_d;
      if (retire) count_q <= count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
    end
  end

  // The ROM already yields CTRL_IDLE in RESET and HALT.
  assign ctrl        = advance ? rom_ctrl : CTRL_IDLE;
  assign stage       = stage_q;
  assign halted      = (stage_q == ST_HALT);
  assign illegal     = rom_illegal;
  assign instr_count = count_q;

endmodule

// File: tb/tb_sap_control_sequencer.sv
// tb_sap_control_sequencer: directed bench with a per-cycle scoreboard.
// The driver sets inputs just after each falling edge and pushes the outputs
// it expects for that cycle; a monitor pops and compares slightly later.
// dut uses ILLEGAL_HALT=0, dut_h uses ILLEGAL_HALT=1; both share inputs.
module tb_sap_control_sequencer;

  localparam int OW = 5;
  localparam int CW = 4;
  localparam int EW = 24;

  localparam logic [14:0] IDLE = 15'h0FE3;
  localparam logic [14:0] F0   = 15'h27E3;
  localparam logic [14:0] F1   = 15'h4FE3;
  localparam logic [14:0] F2   = 15'h0D63;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, flag_c, flag_z, step_mode, step, resume;
  logic [OW-1:0] opcode;
  logic [14:0]   ctrl, ctrl_h;
  logic [2:0]    stage, stage_h;
  logic          halted, halted_h, illegal, illegal_h;
  logic [CW-1:0] instr_count, instr_count_h;

  sap_control_sequencer #(.OPCODE_W(OW), .COUNT_W(CW), .STEP_EN(1), .ILLEGAL_HALT(0)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .flag_c(flag_c), .flag_z(flag_z),
    .step_mode(step_mode), .step(step), .resume(resume), .ctrl(ctrl), .stage(stage),
    .halted(halted), .illegal(illegal), .instr_count(instr_count)
  );

  sap_control_sequencer #(.OPCODE_W(OW), .COUNT_W(CW), .STEP_EN(1), .ILLEGAL_HALT(1)) dut_h (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .flag_c(flag_c), .flag_z(flag_z),
    .step_mode(step_mode), .step(step), .resume(resume), .ctrl(ctrl_h), .stage(stage_h),
    .halted(halted_h), .illegal(illegal_h), .instr_count(instr_count_h)
  );

  // Entry layout: {stage[23:21], ctrl[20:6], halted[5], illegal[4], count[3:0]}
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_h_q[$];
  int checks = 0;
  int errors = 0;
  logic [14:0] step_word[4];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", name, idx, act, expv);
    end
  endtask

  task automatic compare(input string tag, input int idx, input logic [EW-1:0] e,
                         input logic [2:0] s, input logic [14:0] c, input logic h,
                         input logic il, input logic [CW-1:0] n);
    chk({tag, ".stage"}, idx, 32'(s), 32'(e[23:21]));
    chk({tag, ".ctrl"}, idx, 32'(c), 32'(e[20:6]));
    chk({tag, ".halted"}, idx, 32'(h), 32'(e[5]));
    chk({tag, ".illegal"}, idx, 32'(il), 32'(e[4]));
    chk({tag, ".count"}, idx, 32'(n), 32'(e[3:0]));
  endtask

  // Monitor
  initial begin
    int n_main = 0;
    int n_h = 0;
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compare("dut", n_main, e, stage, ctrl, halted, illegal, instr_count);
        n_main++;
      end
      if (exp_h_q.size() > 0) begin
        e = exp_h_q.pop_front();
        compare("dut_h", n_h, e, stage_h, ctrl_h, halted_h, illegal_h, instr_count_h);
        n_h++;
      end
    end
  end

  // Driver tasks
  task automatic exp_cyc(input logic [2:0] s, input logic [14:0] c, input logic h,
                         input logic il, input logic [CW-1:0] n);
    exp_q.push_back({s, c, h, il, n});
    @(negedge clk);
    #1;
  endtask

  task automatic push_h(input logic [2:0] s, input logic [14:0] c, input logic h,
                        input logic il, input logic [CW-1:0] n);
    exp_h_q.push_back({s, c, h, il, n});
  endtask

  task automatic fetch(input logic [CW-1:0] n);
    exp_cyc(3'd0, F0, 1'b0, 1'b0, n);
    exp_cyc(3'd1, F1, 1'b0, 1'b0, n);
    exp_cyc(3'd2, F2, 1'b0, 1'b0, n);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; opcode = '0; flag_c = 1'b0; flag_z = 1'b0;
    step_mode = 1'b0; step = 1'b0; resume = 1'b0;
    step_word[0] = F0; step_word[1] = F1; step_word[2] = F2; step_word[3] = IDLE;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;

    // Reset, then release
    exp_cyc(3'd6, IDLE, 1'b0, 1'b0, 4'd0);
    rst_n = 1'b1;
    exp_cyc(3'd6, IDLE, 1'b0, 1'b0, 4'd0);

    // ADD, SUB
    opcode = 5'd2; fetch(4'd0);
    exp_cyc(3'd3, 15'h07A3, 1'b0, 1'b0, 4'd0);
    exp_cyc(3'd4, 15'h0DE1, 1'b0, 1'b0, 4'd0);
    exp_cyc(3'd5, 15'h0FC7, 1'b0, 1'b0, 4'd0);
    opcode = 5'd3; fetch(4'd1);
    exp_cyc(3'd3, 15'h07A3, 1'b0, 1'b0, 4'd1);
    exp_cyc(3'd4, 15'h0DE1, 1'b0, 1'b0, 4'd1);
    exp_cyc(3'd5, 15'h0FCF, 1'b0, 1'b0, 4'd1);

    // Conditional jumps
    opcode = 5'd9; flag_z = 1'b0; fetch(4'd2);
    exp_cyc(3'd3, IDLE, 1'b0, 1'b0, 4'd2);
    flag_z = 1'b1; fetch(4'd3);
    exp_cyc(3'd3, 15'h1FA3, 1'b0, 1'b0, 4'd3);
    flag_z = 1'b0; opcode = 5'd8; flag_c = 1'b1; fetch(4'd4);
    exp_cyc(3'd3, 15'h1FA3, 1'b0, 1'b0, 4'd4);
    flag_c = 1'b0; fetch(4'd5);
    exp_cyc(3'd3, IDLE, 1'b0, 1'b0, 4'd5);

    // LDA, OUT, STA, JMP
    opcode = 5'd4; fetch(4'd6);
    exp_cyc(3'd3, 15'h07A3, 1'b0, 1'b0, 4'd6);
    exp_cyc(3'd4, 15'h0DC3, 1'b0, 1'b0, 4'd6);
    opcode = 5'd5; fetch(4'd7);
    exp_cyc(3'd3, 15'h0FF2, 1'b0, 1'b0, 4'd7);
    opcode = 5'd6; fetch(4'd8);
    exp_cyc(3'd3, 15'h07A3, 1'b0, 1'b0, 4'd8);
    exp_cyc(3'd4, 15'h0BF3, 1'b0, 1'b0, 4'd8);
    exp_cyc(3'd5, 15'h0EE3, 1'b0, 1'b0, 4'd8);
    opcode = 5'd7; fetch(4'd9);
    exp_cyc(3'd3, 15'h1FA3, 1'b0, 1'b0, 4'd9);

    // HLT: stays halted with step pulsing, leaves on resume
    opcode = 5'd0; fetch(4'd10);
    exp_cyc(3'd3, IDLE, 1'b0, 1'b0, 4'd10);
    for (int i = 0; i < 10; i++) begin
      step = i[0];
      step_mode = (i >= 5);
      exp_cyc(3'd7, IDLE, 1'b1, 1'b0, 4'd11);
    end
    step = 1'b0; step_mode = 1'b0; resume = 1'b1;
    exp_cyc(3'd7, IDLE, 1'b1, 1'b0, 4'd11);
    resume = 1'b0; opcode = 5'd1; fetch(4'd11);
    exp_cyc(3'd3, IDLE, 1'b0, 1'b0, 4'd11);

    // Single-step: a NOP advanced by a step every third cycle
    step_mode = 1'b1;
    for (int st = 0; st < 4; st++) begin
      for (int k = 0; k < 3; k++) begin
        step = (k == 2);
        exp_cyc(3'(st), (k == 2) ? step_word[st] : IDLE, 1'b0, 1'b0, 4'd12);
      end
    end
    step = 1'b0; step_mode = 1'b0;

    // Reset in the middle of ADD: no retire, counter cleared
    opcode = 5'd2; fetch(4'd13);
    rst_n = 1'b0;
    exp_cyc(3'd3, 15'h07A3, 1'b0, 1'b0, 4'd13);
    rst_n = 1'b1;
    exp_cyc(3'd6, IDLE, 1'b0, 1'b0, 4'd0);

    // Sixteen NOPs wrap the 4-bit counter back to 0
    opcode = 5'd1;
    for (int i = 0; i < 16; i++) begin
      fetch(CW'(i));
      exp_cyc(3'd3, IDLE, 1'b0, 1'b0, CW'(i));
    end

    // Illegal opcodes: 12, then an upper bit set
    opcode = 5'd12; fetch(4'd0);
    push_h(3'd3, IDLE, 1'b0, 1'b1, 4'd0);
    exp_cyc(3'd3, IDLE, 1'b0, 1'b1, 4'd0);
    opcode = 5'h11;
    push_h(3'd7, IDLE, 1'b1, 1'b0, 4'd1);
    exp_cyc(3'd0, F0, 1'b0, 1'b0, 4'd1);
    push_h(3'd7, IDLE, 1'b1, 1'b0, 4'd1);
    exp_cyc(3'd1, F1, 1'b0, 1'b0, 4'd1);
    exp_cyc(3'd2, F2, 1'b0, 1'b0, 4'd1);
    exp_cyc(3'd3, IDLE, 1'b0, 1'b1, 4'd1);
    exp_cyc(3'd0, F0, 1'b0, 1'b0, 4'd2);

    @(negedge clk);
    #3;
    chk("queue_drain", 0, 32'(exp_q.size() + exp_h_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
